// File: rtl/serial_mag_comparator.sv
// Bit-serial N-bit magnitude comparator: one 1-bit comparator slice, fed MSB-first, one bit per clock.
// Optional macro SERCMP_EARLY_EXIT_EN ends the compare on the first differing bit.
`default_nettype none

module serial_mag_comparator #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic           e;
  logic           g;
  logic [CW-1:0]  cnt;

  logic           a0;
  logic           b0;
  logic           e1;
  logic           g1;
  logic           last_bit;
  logic           finish;

  // The shift registers present the bit selected by cnt at their MSB.
  assign a0 = a_sh[N-1];
  assign b0 = b_sh[N-1];

  assign e1 = e & ~(a0 ^ b0);
  assign g1 = g | (e & a0 & ~b0);

  assign last_bit = (cnt == '0);

`ifdef SERCMP_EARLY_EXIT_EN
  assign finish = last_bit | ~e1;
`else
  assign finish = last_bit;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)  state_next = RUN;
      RUN:     if (finish) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      e     <= 1'b1;
      g     <= 1'b0;
      cnt   <= '0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            e    <= 1'b1;
            g    <= 1'b0;
            cnt  <= CW'(N - 1);
            eq   <= 1'b0;
            gt   <= 1'b0;
            lt   <= 1'b0;
          end
        end
        RUN: begin
          a_sh <= a_sh << 1;
          b_sh <= b_sh << 1;
          e    <= e1;
          g    <= g1;
          if (!last_bit) cnt <= cnt - CW'(1);
          // On an early exit e1 is 0, so these reduce to eq=0, gt=g1, lt=~g1.
          if (finish) begin
            eq <= e1;
            gt <= g1;
            lt <= ~e1 & ~g1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

`default_nettype wire
